// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Package     : matmul_pkg
// Description : Shared constants and types for the matrix-multiply memory:
//               read latency, return-owner encoding, default bus widths,
//               read-tag record and a saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    // Fixed engine-visible read latency in clock edges
    localparam int MEM_RD_LAT = 2;

    // Default bus geometry
    localparam int DEF_MEM_AW = 16;
    localparam int DEF_MEM_DW = 32;

    // Which requester a read return belongs to
    typedef enum logic {
        OWN_ENG  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    // Tag travelling alongside a launched array read
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   oob;
    } rd_tag_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : (v + 32'd1);
    endfunction

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_mem_if.sv
`default_nettype none
// ============================================================================
// Interface   : matmul_mem_if
// Description : Engine fixed-latency port and host request/grant port of the
//               matmul operand/result memory, plus the sticky range error.
//               master = requester side, slave = memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_mem_if #(
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32
);
    // Engine port
    logic              mem_req;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [MEM_DW-1:0] mem_wdata;
    logic [MEM_DW-1:0] mem_rdata;

    // Host port
    logic              host_req;
    logic              host_write;
    logic [MEM_AW-1:0] host_addr;
    logic [MEM_DW-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [MEM_DW-1:0] host_rdata;

    // Status
    logic              oob_err;

    modport master (
        output mem_req, mem_write, mem_addr, mem_wdata,
        output host_req, host_write, host_addr, host_wdata,
        input  mem_rdata, host_gnt, host_rvalid, host_rdata, oob_err
    );

    modport slave (
        input  mem_req, mem_write, mem_addr, mem_wdata,
        input  host_req, host_write, host_addr, host_wdata,
        output mem_rdata, host_gnt, host_rvalid, host_rdata, oob_err
    );

endinterface : matmul_mem_if
`default_nettype wire

// File: rtl/matmul_mem_sp_ram.sv
`default_nettype none
// ============================================================================
// Module      : matmul_mem_sp_ram
// Description : Plain synchronous single-port word array with a registered
//               read port (one cycle) and write-first behaviour. Contents
//               and the read register are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mem_sp_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // Array write plus registered read; a write also shows its data on the read port
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q       <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : matmul_mem_sp_ram
`default_nettype wire

// File: rtl/matmul_mem.sv
`default_nettype none
// ============================================================================
// Module      : matmul_mem
// Description : Single-port operand/result memory for the matmul engine.
//               The engine port always wins arbitration and sees a fixed
//               two-edge read latency; the host port is granted only when
//               the engine is idle and gets a one-cycle host_rvalid pulse.
//               Out-of-range accesses are dropped/return zero and set a
//               sticky oob_err.
//               Optional: define MATMUL_MEM_STATS_EN to add access/stall
//               counters (stat_clr, stat_eng_cnt, stat_host_cnt,
//               stat_stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mem
    import matmul_pkg::*;
#(
    parameter int MEM_AW     = DEF_MEM_AW,
    parameter int MEM_DW     = DEF_MEM_DW,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MATMUL_MEM_STATS_EN
    input  logic        stat_clr,
    output logic [31:0] stat_eng_cnt,
    output logic [31:0] stat_host_cnt,
    output logic [31:0] stat_stall_cnt,
`endif
    matmul_mem_if.slave bus
);

    // ------------------------------------------------------------------
    // Arbitration and request mux
    // ------------------------------------------------------------------
    logic              w_eng_acc;
    logic              w_host_gnt;
    logic              w_acc;
    logic              w_we;
    logic              w_oob;
    owner_e            w_owner;
    logic [MEM_AW-1:0] w_addr;
    logic [MEM_DW-1:0] w_wdata;
    logic [MEM_DW-1:0] w_ram_rdata;

    // Engine has absolute priority; host only proceeds on engine-idle cycles
    always_comb begin
        w_eng_acc  = bus.mem_req;
        w_host_gnt = bus.host_req & ~bus.mem_req;
        w_acc      = w_eng_acc | w_host_gnt;
        w_we       = bus.host_write;
        w_addr     = bus.host_addr;
        w_wdata    = bus.host_wdata;
        w_owner    = OWN_HOST;
        if (w_eng_acc) begin
            w_we    = bus.mem_write;
            w_addr  = bus.mem_addr;
            w_wdata = bus.mem_wdata;
            w_owner = OWN_ENG;
        end
    end

    // Any address bit above the storage depth marks the access out of range
    generate
        if (DEPTH_LOG2 < MEM_AW) begin : g_oob_chk
            assign w_oob = |w_addr[MEM_AW-1:DEPTH_LOG2];
        end else begin : g_oob_none
            assign w_oob = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage: out-of-range accesses never touch the array
    // ------------------------------------------------------------------
    matmul_mem_sp_ram #(
        .AW (DEPTH_LOG2),
        .DW (MEM_DW)
    ) u_ram (
        .clk     (clk),
        .en_i    (w_acc & ~w_oob),
        .we_i    (w_we),
        .addr_i  (w_addr[DEPTH_LOG2-1:0]),
        .wdata_i (w_wdata),
        .rdata_o (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read-return pipeline: tag launched with the array read, then a
    // second stage carrying the data, then the owner-routed outputs.
    // ------------------------------------------------------------------
    rd_tag_t           s1_d;
    rd_tag_t           s1_q;
    logic              s2_valid_q;
    owner_e            s2_owner_q;
    logic [MEM_DW-1:0] s2_data_d;
    logic [MEM_DW-1:0] s2_data_q;
    logic [MEM_DW-1:0] mem_rdata_q;
    logic [MEM_DW-1:0] host_rdata_q;
    logic              host_rvalid_q;
    logic              oob_err_d;
    logic              oob_err_q;

    // Next-state for the tag stage, masked array data and sticky error
    always_comb begin
        s1_d.valid = w_acc & ~w_we;
        s1_d.owner = w_owner;
        s1_d.oob   = w_oob;
        s2_data_d  = s1_q.oob ? '0 : w_ram_rdata;
        oob_err_d  = oob_err_q | (w_acc & w_oob);
    end

    // Pipeline registers; reset discards every in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_owner_q <= OWN_ENG;
            s2_data_q  <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_valid_q <= s1_q.valid;
            s2_owner_q <= s1_q.owner;
            s2_data_q  <= s2_data_d;
        end
    end

    // Route returns to their owner; data outputs hold between returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata_q   <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            oob_err_q     <= 1'b0;
        end else begin
            host_rvalid_q <= s2_valid_q & (s2_owner_q == OWN_HOST);
            oob_err_q     <= oob_err_d;
            if (s2_valid_q && (s2_owner_q == OWN_ENG)) begin
                mem_rdata_q <= s2_data_q;
            end
            if (s2_valid_q && (s2_owner_q == OWN_HOST)) begin
                host_rdata_q <= s2_data_q;
            end
        end
    end

    assign bus.host_gnt    = w_host_gnt;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.oob_err     = oob_err_q;

`ifdef MATMUL_MEM_STATS_EN
    // ------------------------------------------------------------------
    // Access / stall statistics
    // ------------------------------------------------------------------
    logic [31:0] eng_cnt_q;
    logic [31:0] host_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating counters; a clear request overrides any increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt_q   <= '0;
            host_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (stat_clr) begin
            eng_cnt_q   <= '0;
            host_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (w_eng_acc) begin
                eng_cnt_q <= sat_inc(eng_cnt_q);
            end
            if (w_host_gnt) begin
                host_cnt_q <= sat_inc(host_cnt_q);
            end
            if (bus.host_req && bus.mem_req) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign stat_eng_cnt   = eng_cnt_q;
    assign stat_host_cnt  = host_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule : matmul_mem
`default_nettype wire

// File: tb/tb_matmul_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_mem
// Description : Self-checking bench for matmul_mem: directed scenarios then
//               randomized engine/host traffic against a word-array model
//               with a queue of timed read returns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_mem;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DL2   = 10;
    localparam int DEPTH = 1 << DL2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    matmul_mem_if #(.MEM_AW(AW), .MEM_DW(DW)) bus ();

`ifdef MATMUL_MEM_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_eng_cnt;
    logic [31:0] stat_host_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    matmul_mem #(.MEM_AW(AW), .MEM_DW(DW), .DEPTH_LOG2(DL2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef MATMUL_MEM_STATS_EN
        .stat_clr       (stat_clr),
        .stat_eng_cnt   (stat_eng_cnt),
        .stat_host_cnt  (stat_host_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .bus            (bus)
    );

    // ---------------- reference model state ----------------
    typedef struct {
        int          due;
        bit          host;
        logic [31:0] data;
    } ret_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] mem_m [DEPTH];
    ret_t        rq [$];
    logic [31:0] exp_mrdata, exp_hrdata;
    bit          exp_hrv, exp_oob, last_gnt;
    logic [31:0] m_eng, m_host, m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.host_req   = 1'b0;
        bus.host_write = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
    endtask

    task automatic eng_set(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.mem_req   = 1'b1;
        bus.mem_write = we;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
    endtask

    task automatic host_set(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.host_req   = 1'b1;
        bus.host_write = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
    endtask

    // One clock: check grant, apply the accepted access to the model at the
    // edge, then compare every output half a cycle later.
    task automatic cycle();
        bit              eng, hreq, gnt, we;
        logic [AW-1:0]   a;
        logic [DW-1:0]   wd;
        ret_t            r;
`ifdef MATMUL_MEM_STATS_EN
        bit              clr;
`endif
        #1;
        eng  = bus.mem_req;
        hreq = bus.host_req;
        gnt  = hreq && !eng;
        check("host_gnt", 32'(bus.host_gnt), 32'(gnt));
        last_gnt = gnt;
        we = eng ? bus.mem_write : bus.host_write;
        a  = eng ? bus.mem_addr  : bus.host_addr;
        wd = eng ? bus.mem_wdata : bus.host_wdata;
`ifdef MATMUL_MEM_STATS_EN
        clr = stat_clr;
`endif
        @(posedge clk);
        cyc++;
        if (eng || gnt) begin
            if ((a >> DL2) != 0) begin
                exp_oob = 1'b1;
            end
            if (we) begin
                if ((a >> DL2) == 0) mem_m[a[DL2-1:0]] = wd;
            end else begin
                r.due  = cyc + 2;
                r.host = !eng;
                r.data = ((a >> DL2) == 0) ? mem_m[a[DL2-1:0]] : 32'd0;
                rq.push_back(r);
            end
        end
`ifdef MATMUL_MEM_STATS_EN
        if (clr) begin
            m_eng = 0; m_host = 0; m_stall = 0;
        end else begin
            if (eng && m_eng != 32'hFFFF_FFFF) m_eng++;
            if (gnt && m_host != 32'hFFFF_FFFF) m_host++;
            if (eng && hreq && m_stall != 32'hFFFF_FFFF) m_stall++;
        end
`endif
        @(negedge clk);
        exp_hrv = 1'b0;
        while (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.host) begin
                exp_hrdata = r.data;
                exp_hrv    = 1'b1;
            end else begin
                exp_mrdata = r.data;
            end
        end
        check("mem_rdata",   bus.mem_rdata,          exp_mrdata);
        check("host_rdata",  bus.host_rdata,         exp_hrdata);
        check("host_rvalid", 32'(bus.host_rvalid),   32'(exp_hrv));
        check("oob_err",     32'(bus.oob_err),       32'(exp_oob));
`ifdef MATMUL_MEM_STATS_EN
        check("stat_eng",    stat_eng_cnt,   m_eng);
        check("stat_host",   stat_host_cnt,  m_host);
        check("stat_stall",  stat_stall_cnt, m_stall);
`endif
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle();
`ifdef MATMUL_MEM_STATS_EN
        stat_clr = 1'b0;
`endif
        rq.delete();
        exp_mrdata = '0; exp_hrdata = '0; exp_hrv = 1'b0; exp_oob = 1'b0;
        m_eng = '0; m_host = '0; m_stall = '0;
        #1;
        check("rst_mem_rdata",   bus.mem_rdata,        32'd0);
        check("rst_host_rdata",  bus.host_rdata,       32'd0);
        check("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        check("rst_oob_err",     32'(bus.oob_err),     32'd0);
        check("rst_host_gnt",    32'(bus.host_gnt),    32'd0);
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] raddr();
        int k;
        k = $urandom_range(0, 19);
        if (k < 16)      return AW'(k);
        else if (k < 19) return AW'(DEPTH - 1);
        else             return AW'(DEPTH + $urandom_range(0, 100));
    endfunction

    initial begin
        bit            h_pend;
        bit            h_we;
        logic [AW-1:0] h_a;
        logic [DW-1:0] h_d;

        idle();
        do_reset(2);

        // Host loads 0x11/0x22/0x33, then reads back address 1
        for (int i = 0; i < 3; i++) begin
            host_set(1'b1, AW'(i), 32'(8'h11 * (i + 1)));
            cycle();
        end
        host_set(1'b0, AW'(1), '0);
        cycle();
        idle();
        cycle();
        cycle();
        check("t1_rvalid", 32'(bus.host_rvalid), 32'd1);
        check("t1_rdata",  bus.host_rdata,       32'h22);

        // Engine streams reads of 0,1,2
        for (int i = 0; i < 3; i++) begin
            eng_set(1'b0, AW'(i), '0);
            cycle();
        end
        idle();
        cycle();
        cycle();
        check("t2_last", bus.mem_rdata, 32'h33);
        cycle();

        // Host held off by engine for three cycles, granted on the fourth
        host_set(1'b0, AW'(0), '0);
        eng_set(1'b0, AW'(2), '0);
        repeat (3) cycle();
        bus.mem_req = 1'b0;
        cycle();
        check("t3_gnt4", 32'(last_gnt), 32'd1);
`ifdef MATMUL_MEM_STATS_EN
        check("t3_stall", stat_stall_cnt, 32'd3);
`endif
        idle();
        repeat (3) cycle();

        // Engine read-after-write
        eng_set(1'b1, AW'(5), 32'h0000_ABCD);
        cycle();
        eng_set(1'b0, AW'(5), '0);
        cycle();
        idle();
        cycle();
        cycle();
        check("t4_raw", bus.mem_rdata, 32'h0000_ABCD);

        // Out-of-range host read
        host_set(1'b0, AW'(DEPTH), '0);
        cycle();
        idle();
        cycle();
        cycle();
        check("t5_rdata", bus.host_rdata, 32'd0);
        check("t5_oob",   32'(bus.oob_err), 32'd1);

        // Preload the random address pool through the host port
        for (int i = 0; i < 17; i++) begin
            host_set(1'b1, (i < 16) ? AW'(i) : AW'(DEPTH - 1), $urandom());
            cycle();
        end
        idle();

        // Random mixed traffic; host holds its request until granted
        h_pend = 1'b0;
        h_we = 1'b0; h_a = '0; h_d = '0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 40) eng_set($urandom_range(0, 2) == 0, raddr(), $urandom());
            else                            bus.mem_req = 1'b0;
            if (!h_pend && $urandom_range(0, 99) < 50) begin
                h_pend = 1'b1;
                h_we   = ($urandom_range(0, 2) == 0);
                h_a    = raddr();
                h_d    = $urandom();
            end
            if (h_pend) host_set(h_we, h_a, h_d);
            else        bus.host_req = 1'b0;
`ifdef MATMUL_MEM_STATS_EN
            stat_clr = ($urandom_range(0, 99) < 3);
`endif
            cycle();
            if (last_gnt) h_pend = 1'b0;
        end
        idle();
`ifdef MATMUL_MEM_STATS_EN
        stat_clr = 1'b0;
`endif
        cycle();

        // Reset lands one cycle after an engine read: the read must vanish
        eng_set(1'b0, AW'(1), '0);
        cycle();
        do_reset(2);
        repeat (4) cycle();
        check("t6_mem_rdata", bus.mem_rdata, 32'd0);
        check("t6_oob",       32'(bus.oob_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_matmul_mem
`default_nettype wire
